// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad code-entry controller with grant window, failure lockout and code reprogramming.
//   CLK, RST         clock and asynchronous active-high reset
//   DIGIT_VALID      one-cycle strobe presenting DIGIT
//   DIGIT            keypad digit value
//   CLEAR            abort the current entry or program pass
//   SET_MODE         request code reprogramming while access is granted
//   INIT             high for the grant window (drives the unlock-check stage)
//   LOCKED_OUT       high during lockout
//   BUSY             high in any state other than IDLE
//   FAIL_CNT         consecutive failure count, saturating at 15
//   ENTRY_CNT        digits accepted in the current entry or program pass
module lock_sequencer #(
    parameter int                            CODE_LEN       = 4,
    parameter int                            DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   CODE_RESET     = 16'h1234,
    parameter int                            MAX_FAIL       = 3,
    parameter int                            GRANT_CYCLES   = 8,
    parameter int                            LOCKOUT_CYCLES = 64,
    parameter int                            TIMEOUT_CYCLES = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               DIGIT_VALID,
    input  logic [DIGIT_W-1:0] DIGIT,
    input  logic               CLEAR,
    input  logic               SET_MODE,
    output logic               INIT,
    output logic               LOCKED_OUT,
    output logic               BUSY,
    output logic [3:0]         FAIL_CNT,
    output logic [3:0]         ENTRY_CNT
);
    localparam int CW    = CODE_LEN * DIGIT_W;
    localparam int SW    = (CODE_LEN - 1) * DIGIT_W;
    localparam int T_GL  = GRANT_CYCLES > LOCKOUT_CYCLES ? GRANT_CYCLES : LOCKOUT_CYCLES;
    localparam int T_MAX = T_GL > TIMEOUT_CYCLES ? T_GL : TIMEOUT_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, PROG, FAIL, LOCKOUT} state_t;

    state_t             state, state_n;
    logic               dv_q, clr_q;
    logic [DIGIT_W-1:0] dig_q;
    logic [CW-1:0]      code_reg, code_n, aligned;
    logic [SW-1:0]      shadow, shadow_n;
    logic [TW-1:0]      timer, timer_n;
    logic [3:0]         entry_n, fail_n, fail_inc;
    logic               mism, mism_n, digit_ne, last_digit, gap_out, take;

    // Keypad inputs pass through one register stage, which places CHECK one cycle after
    // the last digit is sampled. Only states that consume keypad input capture it, so
    // strobes presented in CHECK, GRANT, FAIL or LOCKOUT are dropped at the door.
    assign take       = state == IDLE || state == ENTRY || state == PROG;
    // Shift the stored code so the digit expected at position ENTRY_CNT lands in the MS slot.
    assign aligned    = code_reg << (ENTRY_CNT * DIGIT_W);
    assign digit_ne   = dig_q != DIGIT_W'(aligned >> (CW - DIGIT_W));
    assign last_digit = ENTRY_CNT == 4'(CODE_LEN - 1);
    assign gap_out    = timer == TW'(TIMEOUT_CYCLES - 1);
    assign fail_inc   = FAIL_CNT == 4'hF ? 4'hF : FAIL_CNT + 4'd1;

    always_comb begin
        state_n  = state;
        timer_n  = timer + TW'(1);
        entry_n  = ENTRY_CNT;
        fail_n   = FAIL_CNT;
        mism_n   = mism;
        shadow_n = shadow;
        code_n   = code_reg;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (dv_q) begin
                    state_n = ENTRY;
                    entry_n = 4'd1;
                    mism_n  = digit_ne;
                end
            end
            ENTRY: begin
                if (clr_q) begin
                    state_n = IDLE;
                end else if (dv_q) begin
                    timer_n = '0;
                    entry_n = ENTRY_CNT + 4'd1;
                    // Sticky mismatch: the whole code is always collected before judging.
                    mism_n  = mism | digit_ne;
                    if (last_digit) state_n = CHECK;
                end else if (gap_out) begin
                    state_n = IDLE;
                end
            end
            CHECK: begin
                timer_n = '0;
                state_n = mism ? FAIL : GRANT;
                fail_n  = mism ? FAIL_CNT : 4'd0;
            end
            GRANT: begin
                // SET_MODE outranks window expiry so a request in the final cycle still lands in PROG.
                if (SET_MODE) begin
                    state_n = PROG;
                    timer_n = '0;
                    entry_n = '0;
                end else if (timer == TW'(GRANT_CYCLES - 1)) begin
                    state_n = IDLE;
                end
            end
            PROG: begin
                if (clr_q) begin
                    state_n = IDLE;
                end else if (dv_q) begin
                    timer_n  = '0;
                    entry_n  = ENTRY_CNT + 4'd1;
                    shadow_n = SW'({shadow, dig_q});
                    if (last_digit) begin
                        code_n  = {shadow, dig_q};
                        state_n = IDLE;
                    end
                end else if (gap_out) begin
                    state_n = IDLE;
                end
            end
            FAIL: begin
                timer_n = '0;
                fail_n  = fail_inc;
                state_n = fail_inc >= 4'(MAX_FAIL) ? LOCKOUT : IDLE;
            end
            LOCKOUT: begin
                if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE) begin
            entry_n = '0;
            timer_n = '0;
            mism_n  = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            timer      <= '0;
            mism       <= 1'b0;
            shadow     <= '0;
            code_reg   <= CODE_RESET;
            dv_q       <= 1'b0;
            clr_q      <= 1'b0;
            dig_q      <= '0;
            ENTRY_CNT  <= '0;
            FAIL_CNT   <= '0;
            INIT       <= 1'b0;
            LOCKED_OUT <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            mism       <= mism_n;
            shadow     <= shadow_n;
            code_reg   <= code_n;
            dv_q       <= DIGIT_VALID && take;
            clr_q      <= CLEAR && take;
            dig_q      <= DIGIT;
            ENTRY_CNT  <= entry_n;
            FAIL_CNT   <= fail_n;
            INIT       <= state_n == GRANT;
            LOCKED_OUT <= state_n == LOCKOUT;
            BUSY       <= state_n != IDLE;
        end
    end
endmodule
